// File: rtl/nf10_axis_pkg.sv
// Shared definitions for the nf10 AXI4-Stream upsizer: tuser field layout,
// the metadata record and a strobe popcount helper.
package nf10_axis_pkg;

    localparam int LEN_LO       = 0;
    localparam int LEN_HI       = 15;
    localparam int SRC_LO       = 16;
    localparam int SRC_HI       = 23;
    localparam int DST_LO       = 24;
    localparam int DST_HI       = 31;
    localparam int OVERSIZE_BIT = 32;

    localparam int META_W       = 17;
    localparam int POPCOUNT_W   = 256;

    typedef struct packed {
        logic        oversize;
        logic [15:0] len;
    } meta_rec_t;

    function automatic logic [15:0] popcount(input logic [POPCOUNT_W-1:0] v);
        logic [15:0] cnt;
        cnt = '0;
        for (int i = 0; i < POPCOUNT_W; i++) begin
            cnt = cnt + {15'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fall-through FIFO: dout always shows the head entry,
// rd_en retires it. nearly_full leaves one free entry of slack.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 8,
    parameter int MAX_DEPTH_BITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty
);

    localparam int DEPTH = 1 << MAX_DEPTH_BITS;

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [MAX_DEPTH_BITS:0]   depth;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            depth  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   depth <= depth + 1'b1;
                2'b01:   depth <= depth - 1'b1;
                default: depth <= depth;
            endcase
        end
    end

    assign dout        = mem[rd_ptr];
    assign empty       = (depth == '0);
    assign nearly_full = (depth >= (MAX_DEPTH_BITS+1)'(DEPTH - 1));

endmodule

// File: rtl/nf10_axis_upsizer.sv
// AXI4-Stream width upsizer: packs R narrow slave beats per master beat and
// prepends LEN/SRC/DST/oversize metadata in tuser on each packet's first beat.
module nf10_axis_upsizer
    import nf10_axis_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = 64,
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_DEFAULT_SRC_PORT   = 0,
    parameter int C_DEFAULT_DST_PORT   = 0,
    parameter int C_FIFO_DEPTH_BITS    = 8,
    parameter int C_MAX_PKT_BEATS      = 240
) (
    input  logic                              axi_aclk,
    input  logic                              axi_reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic [31:0]                       stat_pkt_count,
    output logic [15:0]                       stat_oversize_count
);

    localparam int S      = C_S_AXIS_DATA_WIDTH;
    localparam int M      = C_M_AXIS_DATA_WIDTH;
    localparam int SB     = S / 8;
    localparam int MB     = M / 8;
    localparam int R      = M / S;
    localparam int LANE_W = $clog2(R);
    localparam int DW     = S + SB + 1;

    localparam logic [LANE_W-1:0] PENULT_LANE     = LANE_W'(R - 2);
    localparam logic [15:0]       FULL_BEAT_BYTES = 16'(SB);
    localparam logic [15:0]       MAX_BEATS       = 16'(C_MAX_PKT_BEATS);

    localparam logic [1:0] M_IDLE = 2'd0;
    localparam logic [1:0] M_DATA = 2'd1;
    localparam logic [1:0] M_SKIP = 2'd2;

    localparam logic [1:0] P_IDLE = 2'd0;
    localparam logic [1:0] P_FILL = 2'd1;
    localparam logic [1:0] P_OUT  = 2'd2;

    logic            data_nf, data_empty, data_rd;
    logic [DW-1:0]   data_dout;
    logic            meta_nf, meta_empty, meta_rd, meta_wr;
    meta_rec_t       meta_din, meta_dout;
    logic            s_fire, m_fire, fill_pop;

    // Slave handshake: beat goes to the data FIFO, bookkeeping to the builder.
    assign s_axis_tready = !axi_reset && !data_nf && !meta_nf;
    assign s_fire        = s_axis_tvalid && s_axis_tready;

    fallthrough_small_fifo #(
        .WIDTH          (DW),
        .MAX_DEPTH_BITS (C_FIFO_DEPTH_BITS)
    ) u_data_fifo (
        .clk         (axi_aclk),
        .reset       (axi_reset),
        .din         ({s_axis_tlast, s_axis_tstrb, s_axis_tdata}),
        .wr_en       (s_fire),
        .rd_en       (data_rd),
        .dout        (data_dout),
        .nearly_full (data_nf),
        .empty       (data_empty)
    );

    fallthrough_small_fifo #(
        .WIDTH          (META_W),
        .MAX_DEPTH_BITS (C_FIFO_DEPTH_BITS)
    ) u_meta_fifo (
        .clk         (axi_aclk),
        .reset       (axi_reset),
        .din         (meta_din),
        .wr_en       (meta_wr),
        .rd_en       (meta_rd),
        .dout        (meta_dout),
        .nearly_full (meta_nf),
        .empty       (meta_empty)
    );

    // Metadata builder
    logic [1:0]  m_state;
    logic [15:0] byte_cnt, beat_cnt, byte_next, beat_next, beat_add;
    logic [16:0] byte_sum;

    always_comb begin
        beat_add  = s_axis_tlast ? popcount(POPCOUNT_W'(s_axis_tstrb)) : FULL_BEAT_BYTES;
        byte_sum  = {1'b0, byte_cnt} + {1'b0, beat_add};
        byte_next = byte_sum[16] ? 16'hFFFF : byte_sum[15:0];
        beat_next = beat_cnt + 16'd1;
        meta_wr           = 1'b0;
        meta_din.len      = byte_next;
        meta_din.oversize = 1'b0;
        if (s_fire && m_state != M_SKIP) begin
            if (s_axis_tlast) begin
                meta_wr = 1'b1;
            end else if (beat_next == MAX_BEATS) begin
                meta_wr           = 1'b1;
                meta_din.oversize = 1'b1;
            end
        end
    end

    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            m_state             <= M_IDLE;
            byte_cnt            <= '0;
            beat_cnt            <= '0;
            stat_oversize_count <= '0;
        end else if (s_fire) begin
            if (m_state == M_SKIP) begin
                if (s_axis_tlast) begin
                    m_state <= M_IDLE;
                end
            end else if (s_axis_tlast) begin
                m_state  <= M_IDLE;
                byte_cnt <= '0;
                beat_cnt <= '0;
            end else if (beat_next == MAX_BEATS) begin
                m_state  <= M_SKIP;
                byte_cnt <= '0;
                beat_cnt <= '0;
                if (stat_oversize_count != 16'hFFFF) begin
                    stat_oversize_count <= stat_oversize_count + 16'd1;
                end
            end else begin
                m_state  <= M_DATA;
                byte_cnt <= byte_next;
                beat_cnt <= beat_next;
            end
        end
    end

    // Packer: lanes below the current one are registered, the current lane
    // is the FIFO head, so the closing beat is only retired on m_axis_tready.
    logic [1:0]        p_state;
    logic [LANE_W-1:0] lane;
    logic              first_beat;
    meta_rec_t         rec;
    logic [M-1:0]      word_data, out_data;
    logic [MB-1:0]     word_strb, out_strb;
    logic [C_M_AXIS_TUSER_WIDTH-1:0] tuser_word;
    logic [S-1:0]      head_data;
    logic [SB-1:0]     head_strb;
    logic              head_last;

    assign head_data = data_dout[S-1:0];
    assign head_strb = data_dout[S +: SB];
    assign head_last = data_dout[DW-1];

    assign m_axis_tvalid = (p_state == P_OUT) && !data_empty;
    assign m_fire        = m_axis_tvalid && m_axis_tready;
    assign fill_pop      = (p_state == P_FILL) && !data_empty && !head_last;
    assign data_rd       = fill_pop || m_fire;
    assign meta_rd       = m_fire && first_beat;

    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            p_state        <= P_IDLE;
            lane           <= '0;
            first_beat     <= 1'b0;
            rec            <= '0;
            word_data      <= '0;
            word_strb      <= '0;
            stat_pkt_count <= '0;
        end else begin
            case (p_state)
                P_IDLE: begin
                    if (!data_empty && !meta_empty) begin
                        rec        <= meta_dout;
                        lane       <= '0;
                        first_beat <= 1'b1;
                        word_data  <= '0;
                        word_strb  <= '0;
                        p_state    <= P_FILL;
                    end
                end
                P_FILL: begin
                    if (!data_empty) begin
                        if (head_last) begin
                            p_state <= P_OUT;
                        end else begin
                            word_data[lane*S +: S]   <= head_data;
                            word_strb[lane*SB +: SB] <= head_strb;
                            lane                     <= lane + 1'b1;
                            if (lane == PENULT_LANE) begin
                                p_state <= P_OUT;
                            end
                        end
                    end
                end
                P_OUT: begin
                    if (m_fire) begin
                        first_beat <= 1'b0;
                        lane       <= '0;
                        word_data  <= '0;
                        word_strb  <= '0;
                        if (head_last) begin
                            p_state        <= P_IDLE;
                            stat_pkt_count <= stat_pkt_count + 32'd1;
                        end else begin
                            p_state <= P_FILL;
                        end
                    end
                end
                default: p_state <= P_IDLE;
            endcase
        end
    end

    always_comb begin
        out_data                   = word_data;
        out_strb                   = word_strb;
        out_data[lane*S +: S]      = head_data;
        out_strb[lane*SB +: SB]    = head_strb;
        tuser_word                 = '0;
        tuser_word[LEN_HI:LEN_LO]  = rec.len;
        tuser_word[SRC_HI:SRC_LO]  = 8'(C_DEFAULT_SRC_PORT);
        tuser_word[DST_HI:DST_LO]  = 8'(C_DEFAULT_DST_PORT);
        tuser_word[OVERSIZE_BIT]   = rec.oversize;
        m_axis_tdata = m_axis_tvalid ? out_data : '0;
        m_axis_tstrb = m_axis_tvalid ? out_strb : '0;
        m_axis_tuser = (m_axis_tvalid && first_beat) ? tuser_word : '0;
        m_axis_tlast = m_axis_tvalid && head_last;
    end

endmodule

// File: tb/tb_nf10_axis_upsizer.sv
// Self-checking bench for nf10_axis_upsizer (64 -> 256 bit, 240-beat oversize limit).
module tb_nf10_axis_upsizer;

    localparam int S     = 64;
    localparam int M     = 256;
    localparam int SB    = S / 8;
    localparam int MB    = M / 8;
    localparam int R     = M / S;
    localparam int TU    = 128;
    localparam int MAXB  = 240;
    localparam int SRC   = 8'h5A;
    localparam int DST   = 8'hA3;
    localparam int EXP_W = M + MB + TU + 1;

    logic           clk;
    logic           axi_reset;
    logic [S-1:0]   s_axis_tdata;
    logic [SB-1:0]  s_axis_tstrb;
    logic           s_axis_tvalid;
    logic           s_axis_tready;
    logic           s_axis_tlast;
    logic [M-1:0]   m_axis_tdata;
    logic [MB-1:0]  m_axis_tstrb;
    logic [TU-1:0]  m_axis_tuser;
    logic           m_axis_tvalid;
    logic           m_axis_tready;
    logic           m_axis_tlast;
    logic [31:0]    stat_pkt_count;
    logic [15:0]    stat_oversize_count;

    logic [EXP_W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int pkts_sent = 0;
    int oversize_sent = 0;
    logic rand_ready = 1'b0;

    logic           held;
    logic [M-1:0]   held_data;
    logic [MB-1:0]  held_strb;
    logic [TU-1:0]  held_user;
    logic           held_last;

    nf10_axis_upsizer #(
        .C_S_AXIS_DATA_WIDTH  (S),
        .C_M_AXIS_DATA_WIDTH  (M),
        .C_M_AXIS_TUSER_WIDTH (TU),
        .C_DEFAULT_SRC_PORT   (SRC),
        .C_DEFAULT_DST_PORT   (DST),
        .C_FIFO_DEPTH_BITS    (8),
        .C_MAX_PKT_BEATS      (MAXB)
    ) dut (
        .axi_aclk            (clk),
        .axi_reset           (axi_reset),
        .s_axis_tdata        (s_axis_tdata),
        .s_axis_tstrb        (s_axis_tstrb),
        .s_axis_tvalid       (s_axis_tvalid),
        .s_axis_tready       (s_axis_tready),
        .s_axis_tlast        (s_axis_tlast),
        .m_axis_tdata        (m_axis_tdata),
        .m_axis_tstrb        (m_axis_tstrb),
        .m_axis_tuser        (m_axis_tuser),
        .m_axis_tvalid       (m_axis_tvalid),
        .m_axis_tready       (m_axis_tready),
        .m_axis_tlast        (m_axis_tlast),
        .stat_pkt_count      (stat_pkt_count),
        .stat_oversize_count (stat_oversize_count)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // driver tasks (called at a negedge, return at a negedge)
    task automatic drive_beat(input logic [S-1:0] d, input logic [SB-1:0] s, input logic l);
        int waits;
        waits = 0;
        s_axis_tdata  = d;
        s_axis_tstrb  = s;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && waits < 2000) begin
            @(negedge clk);
            waits++;
        end
        check_eq("s_ready", 256'(s_axis_tready), 256'(1));
        @(negedge clk);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int n, input logic [SB-1:0] last_strb);
        logic [S-1:0]  d [300];
        logic [SB-1:0] s [300];
        logic [15:0]   len;
        logic          ovs;
        int            nw;
        for (int i = 0; i < n; i++) begin
            d[i] = {$urandom(), $urandom()};
            s[i] = (i == n - 1) ? last_strb : {SB{1'b1}};
        end
        ovs = (n > MAXB);
        len = ovs ? 16'(MAXB * SB) : 16'((n - 1) * SB + $countones(last_strb));
        nw  = (n + R - 1) / R;
        for (int w = 0; w < nw; w++) begin
            logic [M-1:0]  wd;
            logic [MB-1:0] ws;
            logic [TU-1:0] wu;
            logic          wl;
            wd = '0;
            ws = '0;
            wu = '0;
            for (int l = 0; l < R; l++) begin
                if (w * R + l < n) begin
                    wd[l*S +: S]   = d[w*R + l];
                    ws[l*SB +: SB] = s[w*R + l];
                end
            end
            if (w == 0) begin
                wu[15:0]  = len;
                wu[23:16] = 8'(SRC);
                wu[31:24] = 8'(DST);
                wu[32]    = ovs;
            end
            wl = (w == nw - 1);
            exp_q.push_back({wd, ws, wu, wl});
        end
        pkts_sent++;
        if (ovs) oversize_sent++;
        for (int i = 0; i < n; i++) begin
            drive_beat(d[i], s[i], i == n - 1);
            if (rand_ready && $urandom_range(0, 3) == 0) @(negedge clk);
        end
    endtask

    task automatic wait_drain();
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("drain", 256'(exp_q.size()), 256'(0));
        repeat (2) @(negedge clk);
    endtask

    task automatic check_outputs_idle(input string tag);
        check_eq({tag, "_m_valid"}, 256'(m_axis_tvalid), 256'(0));
        check_eq({tag, "_m_data"},  256'(m_axis_tdata),  256'(0));
        check_eq({tag, "_m_strb"},  256'(m_axis_tstrb),  256'(0));
        check_eq({tag, "_m_user"},  256'(m_axis_tuser),  256'(0));
        check_eq({tag, "_m_last"},  256'(m_axis_tlast),  256'(0));
        check_eq({tag, "_s_ready"}, 256'(s_axis_tready), 256'(0));
    endtask

    // scoreboard: compare every accepted master beat, and stability while stalled
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (axi_reset) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check_eq("hold_valid", 256'(m_axis_tvalid), 256'(1));
                check_eq("hold_data",  256'(m_axis_tdata),  256'(held_data));
                check_eq("hold_strb",  256'(m_axis_tstrb),  256'(held_strb));
                check_eq("hold_user",  256'(m_axis_tuser),  256'(held_user));
                check_eq("hold_last",  256'(m_axis_tlast),  256'(held_last));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_beat", 256'(exp_q.size()), 256'(1));
                end else begin
                    e = exp_q.pop_front();
                    check_eq("tdata", 256'(m_axis_tdata), 256'(e[EXP_W-1 -: M]));
                    check_eq("tstrb", 256'(m_axis_tstrb), 256'(e[TU+1 +: MB]));
                    check_eq("tuser", 256'(m_axis_tuser), 256'(e[1 +: TU]));
                    check_eq("tlast", 256'(m_axis_tlast), 256'(e[0]));
                end
            end
            held      = m_axis_tvalid && !m_axis_tready;
            held_data = m_axis_tdata;
            held_strb = m_axis_tstrb;
            held_user = m_axis_tuser;
            held_last = m_axis_tlast;
        end
    end

    initial begin
        axi_reset     = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tstrb  = '0;
        s_axis_tlast  = 1'b0;
        held          = 1'b0;
        #2 axi_reset = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_idle("reset");
        check_eq("reset_pkt_cnt", 256'(stat_pkt_count), 256'(0));
        check_eq("reset_ovs_cnt", 256'(stat_oversize_count), 256'(0));
        axi_reset = 1'b0;
        @(negedge clk);
        check_eq("ready_after_reset", 256'(s_axis_tready), 256'(1));

        // directed packets, master always ready
        send_pkt(3, 8'h0F);
        send_pkt(9, 8'hFF);
        send_pkt(1, 8'h05);
        wait_drain();
        check_eq("pkt_cnt_directed", 256'(stat_pkt_count), 256'(pkts_sent));

        send_pkt(300, 8'hFF);
        wait_drain();
        check_eq("ovs_cnt", 256'(stat_oversize_count), 256'(oversize_sent));
        check_eq("pkt_cnt_oversize", 256'(stat_pkt_count), 256'(pkts_sent));

        // random back-to-back packets with random backpressure
        rand_ready = 1'b1;
        for (int p = 0; p < 30; p++) begin
            send_pkt($urandom_range(1, 20), 8'($urandom_range(0, 255)));
        end
        wait_drain();
        check_eq("pkt_cnt_random", 256'(stat_pkt_count), 256'(pkts_sent));
        rand_ready = 1'b0;

        // reset in the middle of a packet
        for (int i = 0; i < 5; i++) begin
            drive_beat({$urandom(), $urandom()}, 8'hFF, 1'b0);
        end
        axi_reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_outputs_idle("midreset");
        end
        axi_reset     = 1'b0;
        pkts_sent     = 0;
        oversize_sent = 0;
        @(negedge clk);
        check_eq("post_reset_pkt_cnt", 256'(stat_pkt_count), 256'(0));
        check_eq("post_reset_ovs_cnt", 256'(stat_oversize_count), 256'(0));
        send_pkt(6, 8'h3F);
        wait_drain();
        check_eq("pkt_cnt_after_reset", 256'(stat_pkt_count), 256'(pkts_sent));
        check_eq("ovs_cnt_after_reset", 256'(stat_oversize_count), 256'(oversize_sent));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
